// File: rtl/trng_pkg.sv
// Shared types and width helpers for the single-bit TRNG entropy responder.
package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_SECOND,
        ST_READY,
        ST_FAILED
    } trng_state_t;

    // Divider counts 0..SAMPLE_DIV-1.
    function automatic int unsigned div_width(input int unsigned sample_div);
        return $clog2(sample_div);
    endfunction

    // Repetition counter must hold the value REP_LIMIT itself.
    function automatic int unsigned rep_width(input int unsigned rep_limit);
        return $clog2(rep_limit + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop 1-bit synchronizer with synchronous active-high reset to 0.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/trng_bit_source.sv
// Single-bit entropy responder: divided-tick sampling, von Neumann debiasing,
// EN/ACK handshake and a sticky repetition-count health test.
module trng_bit_source
    import trng_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV  = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned REP_LIMIT   = 32
) (
    input  logic CLK,
    input  logic RST,
    input  logic ENTROPY_IN,
    input  logic EN,
    input  logic ACK,
    output logic RANDOM,
    output logic BIT_READY,
    output logic FAULT
);

    localparam int unsigned      DIV_W    = div_width(SAMPLE_DIV);
    localparam int unsigned      REP_W    = rep_width(REP_LIMIT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);

    trng_state_t      r_state;
    trng_state_t      w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [REP_W-1:0] r_rep;
    logic [REP_W-1:0] w_rep_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             r_sample_a;
    logic             w_sample_a_nxt;
    logic             r_random;
    logic             w_random_nxt;
    logic             r_bit_ready;
    logic             r_fault;

    logic             w_sample;
    logic             w_tick;
    logic             w_rep_same;
    logic [REP_W-1:0] w_rep_cnt;
    logic             w_rep_trip;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .i_d (ENTROPY_IN),
        .o_q (w_sample)
    );

    // Run length including the sample taken this cycle; a zero count means no
    // sample has been seen since IDLE.
    assign w_tick     = (r_div == DIV_LAST);
    assign w_rep_same = (r_rep != '0) && (w_sample == r_last);
    assign w_rep_cnt  = !w_rep_same        ? REP_W'(1) :
                        (r_rep == REP_MAX) ? REP_MAX   :
                                             r_rep + REP_W'(1);
    assign w_rep_trip = (w_rep_cnt == REP_MAX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_div       <= '0;
            r_rep       <= '0;
            r_last      <= 1'b0;
            r_sample_a  <= 1'b0;
            r_random    <= 1'b0;
            r_bit_ready <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_rep       <= w_rep_nxt;
            r_last      <= w_last_nxt;
            r_sample_a  <= w_sample_a_nxt;
            r_random    <= w_random_nxt;
            r_bit_ready <= (w_state_nxt == ST_READY);
            r_fault     <= (w_state_nxt == ST_FAILED);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div;
        w_rep_nxt      = r_rep;
        w_last_nxt     = r_last;
        w_sample_a_nxt = r_sample_a;
        w_random_nxt   = r_random;

        case (r_state)
            ST_IDLE: begin
                w_div_nxt = '0;
                w_rep_nxt = '0;
                if (EN) begin
                    w_state_nxt = ST_FIRST;
                end
            end

            ST_FIRST: begin
                if (!EN) begin
                    w_state_nxt = ST_IDLE;
                    w_div_nxt   = '0;
                    w_rep_nxt   = '0;
                end else if (w_tick) begin
                    w_div_nxt      = '0;
                    w_rep_nxt      = w_rep_cnt;
                    w_last_nxt     = w_sample;
                    w_sample_a_nxt = w_sample;
                    w_state_nxt    = w_rep_trip ? ST_FAILED : ST_SECOND;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end

            ST_SECOND: begin
                if (!EN) begin
                    w_state_nxt = ST_IDLE;
                    w_div_nxt   = '0;
                    w_rep_nxt   = '0;
                end else if (w_tick) begin
                    w_div_nxt  = '0;
                    w_rep_nxt  = w_rep_cnt;
                    w_last_nxt = w_sample;
                    // Health trip outranks the pair result of the same tick.
                    if (w_rep_trip) begin
                        w_state_nxt = ST_FAILED;
                    end else if (w_sample != r_sample_a) begin
                        w_random_nxt = r_sample_a;
                        w_state_nxt  = ST_READY;
                    end else begin
                        w_state_nxt = ST_FIRST;
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end

            ST_READY: begin
                w_div_nxt = '0;
                if (ACK) begin
                    if (EN) begin
                        w_state_nxt = ST_FIRST;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_rep_nxt   = '0;
                    end
                end
            end

            ST_FAILED: begin
                w_div_nxt = '0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_div_nxt   = '0;
                w_rep_nxt   = '0;
            end
        endcase
    end

    assign RANDOM    = r_random;
    assign BIT_READY = r_bit_ready;
    assign FAULT     = r_fault;

endmodule

// File: tb/tb_trng_bit_source.sv
// Randomized bench for trng_bit_source against a per-request sample-sequence model.
module tb_trng_bit_source;

    localparam int SD = 4;
    localparam int SS = 2;
    localparam int RL = 8;
    localparam int NS = 32;

    logic CLK = 1'b0;
    logic RST;
    logic ENTROPY_IN;
    logic EN;
    logic ACK;
    logic RANDOM;
    logic BIT_READY;
    logic FAULT;

    int   n_vec = 0;
    int   n_err = 0;
    logic last_rnd = 1'b0;
    bit   smp [NS];

    trng_bit_source #(
        .SAMPLE_DIV  (SD),
        .SYNC_STAGES (SS),
        .REP_LIMIT   (RL)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ENTROPY_IN (ENTROPY_IN),
        .EN         (EN),
        .ACK        (ACK),
        .RANDOM     (RANDOM),
        .BIT_READY  (BIT_READY),
        .FAULT      (FAULT)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    // Walk the raw samples in pairs: run-length trip first, then a differing pair.
    task automatic model(output bit is_fault, output int ev, output bit val);
        int  run;
        bit  done;
        run      = 0;
        done     = 1'b0;
        is_fault = 1'b0;
        ev       = -1;
        val      = 1'b0;
        for (int k = 0; k < NS && !done; k++) begin
            if (k > 0 && smp[k] == smp[k-1]) run = (run < RL) ? run + 1 : run;
            else run = 1;
            if (run >= RL) begin
                is_fault = 1'b1;
                ev       = SD * (k + 1) + 1;
                done     = 1'b1;
            end else if ((k % 2) == 1 && smp[k] != smp[k-1]) begin
                ev   = SD * (k + 1) + 1;
                val  = smp[k-1];
                done = 1'b1;
            end
        end
    endtask

    task automatic gen_samples(input int mode);
        smp[0] = 1'($urandom_range(0, 1));
        for (int k = 1; k < NS; k++) begin
            case (mode)
                0:       smp[k] = 1'($urandom_range(0, 1));
                1:       smp[k] = ($urandom_range(0, 7) != 0) ? smp[k-1] : ~smp[k-1];
                default: smp[k] = smp[k-1];
            endcase
        end
        if (mode != 2) smp[NS-1] = ~smp[NS-2];
    endtask

    task automatic do_reset();
        RST = 1'b1;
        EN  = 1'b0;
        ACK = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check_eq("rst_random", RANDOM, 1'b0);
        check_eq("rst_ready", BIT_READY, 1'b0);
        check_eq("rst_fault", FAULT, 1'b0);
        last_rnd = 1'b0;
    endtask

    // One request from IDLE; cycle 0 is the first cycle with EN high.
    task automatic run_txn(input int en_off, input int ack_off, input bit stray);
        bit is_f;
        bit val;
        int ev;
        int last;
        model(is_f, ev, val);
        last = is_f ? ev + 6 : ev + ack_off + 3;
        for (int cyc = 0; cyc <= last; cyc++) begin
            if (is_f) begin
                check_eq($sformatf("fault@%0d", cyc), FAULT, cyc >= ev);
                check_eq($sformatf("ready@%0d", cyc), BIT_READY, 1'b0);
                check_eq($sformatf("random@%0d", cyc), RANDOM, last_rnd);
            end else begin
                check_eq($sformatf("ready@%0d", cyc), BIT_READY, (cyc >= ev) && (cyc <= ev + ack_off));
                check_eq($sformatf("fault@%0d", cyc), FAULT, 1'b0);
                check_eq($sformatf("random@%0d", cyc), RANDOM, (cyc >= ev) ? val : last_rnd);
            end
            if (cyc == 0) ENTROPY_IN = smp[0];
            else if ((cyc % SD) == 1 && (cyc / SD) < NS) ENTROPY_IN = smp[cyc / SD];
            if (is_f) begin
                EN  = (cyc < ev) ? 1'b1 : 1'($urandom_range(0, 1));
                ACK = (cyc < ev && !stray) ? 1'b0 : 1'($urandom_range(0, 1));
            end else begin
                EN = (cyc < ev + en_off);
                if (cyc == ev + ack_off) ACK = 1'b1;
                else if (cyc < ev && stray) ACK = ($urandom_range(0, 3) == 0);
                else ACK = 1'b0;
            end
            @(negedge CLK);
        end
        EN  = 1'b0;
        ACK = 1'b0;
        if (is_f) do_reset();
        else last_rnd = val;
    endtask

    initial begin
        ENTROPY_IN = 1'b0;
        do_reset();

        // Single bit: pair 10, ready at 9, EN dropped at 10, ACK at 20.
        smp[0] = 1'b1;
        smp[1] = 1'b0;
        for (int k = 2; k < NS; k++) smp[k] = 1'b0;
        run_txn(1, 11, 1'b0);

        // Reset mid-SECOND clears the held bit; nothing rises with EN low.
        EN = 1'b1;
        ENTROPY_IN = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) @(negedge CLK);
        do_reset();
        for (int cyc = 0; cyc < 20; cyc++) begin
            check_eq($sformatf("idle_ready@%0d", cyc), BIT_READY, 1'b0);
            ENTROPY_IN = 1'($urandom_range(0, 1));
            ACK = 1'($urandom_range(0, 1));
            @(negedge CLK);
        end
        ACK = 1'b0;

        // Discarded pairs 00, 11 then 01.
        smp[0] = 1'b0; smp[1] = 1'b0; smp[2] = 1'b1;
        smp[3] = 1'b1; smp[4] = 1'b0; smp[5] = 1'b1;
        run_txn(1, 3, 1'b0);

        // Abort in SECOND at cycle 6, restart at cycle 10 with pair 10.
        EN = 1'b1;
        ENTROPY_IN = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            check_eq($sformatf("abort_ready@%0d", cyc), BIT_READY, 1'b0);
            EN = (cyc < 6);
            @(negedge CLK);
        end
        smp[0] = 1'b1;
        smp[1] = 1'b0;
        run_txn(0, 2, 1'b0);

        // Stuck source trips the health test at cycle 33.
        for (int k = 0; k < NS; k++) smp[k] = 1'b1;
        run_txn(0, 0, 1'b1);

        // Stray ACKs before READY, ACK in the first READY cycle.
        gen_samples(0);
        run_txn(0, 0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            int sel;
            int eo;
            sel = $urandom_range(0, 9);
            gen_samples(sel < 6 ? 0 : (sel < 9 ? 1 : 2));
            eo = $urandom_range(0, 3);
            run_txn(eo, eo + $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trng_bit_source.md
# trng_bit_source

Single-bit entropy responder behind the `EN`/`RANDOM`/`BIT_READY`/`ACK` handshake used by the random-word collector. One instance exists per collected bit.

- Samples an asynchronous ring-oscillator net on a divided clock tick.
- Removes bias with a von Neumann extractor.
- Presents one debiased bit and holds it until the collector acknowledges it.
- Runs a repetition-count health test and latches `FAULT` on a stuck source.

## Interface
Parameters:
- `SAMPLE_DIV`, 16: clocks between entropy samples; must be ≥ 2.
- `SYNC_STAGES`, 2: flops in the entropy synchronizer; must be ≥ 2.
- `REP_LIMIT`, 32: consecutive identical raw samples that trip `FAULT`.

Ports:
- `CLK` in 1: system clock; single clock domain.
- `RST` in 1: reset, synchronous and active-high.
- `ENTROPY_IN` in 1: asynchronous ring-oscillator output.
- `EN` in 1: collector requests a bit.
- `ACK` in 1: collector has consumed `RANDOM`.
- `RANDOM` out 1: debiased bit; valid while `BIT_READY` is high.
- `BIT_READY` out 1: bit available; held high until `ACK`.
- `FAULT` out 1: sticky health-test failure.

## Operation
- States: `IDLE`, `FIRST`, `SECOND`, `READY`, `FAILED`.
- **Sample tick:** the tick fires when the divider count equals `SAMPLE_DIV-1`. The count is cleared on every entry to `FIRST` or `SECOND`.
- **Sample value:** the raw sample is the synchronizer output in the tick cycle.
- **IDLE:**
  - `EN`=1 → `FIRST`.
  - Otherwise stay; the divider is held at 0.
- **FIRST:**
  - On tick, store sample a → `SECOND`.
  - `EN`=0 → `IDLE`; the partial pair is discarded.
- **SECOND:**
  - On tick, take sample b.
  - a≠b: `RANDOM`←a → `READY`.
  - a=b: discard the pair → `FIRST`.
  - `EN`=0 → `IDLE`.
- **READY:**
  - `BIT_READY`=1 and `RANDOM` is stable.
  - `EN` is ignored; the collector deasserts `EN` while `BIT_READY` is high, and the bit is still held.
  - `ACK`=1 → `FIRST` if `EN`=1, else `IDLE`.
  - No sampling and no health counting occur here.
- **Repetition counter:**
  - Counts consecutive equal raw samples across pairs, saturating at `REP_LIMIT`.
  - Cleared on entry to `IDLE`.
  - First sample after `IDLE` → count 1.
  - Count reaching `REP_LIMIT` → `FAILED` on the next edge; this takes priority over the pair result of the same tick.
- **FAILED:** `FAULT`=1 and `BIT_READY`=0; `EN` and `ACK` are ignored. Only `RST` exits this state.
- **ACK outside READY:** ignored.

## Timing
- **Reset:** `RANDOM`=0, `BIT_READY`=0, `FAULT`=0, state `IDLE`. The divider, repetition counter, stored sample and synchronizer flops are all 0. `RST` mid-operation discards everything on the next edge.
- **Latency:** `EN` first high in cycle t → tick 1 at t+`SAMPLE_DIV`, tick 2 at t+2·`SAMPLE_DIV`. With a differing first pair, `BIT_READY` is high from cycle t+2·`SAMPLE_DIV`+1. Each discarded pair adds 2·`SAMPLE_DIV` cycles.
- **Entropy delay:** `ENTROPY_IN` reaches the sampler `SYNC_STAGES` cycles later.
- **ACK:** `ACK` in any `READY` cycle, including the first, drops `BIT_READY` on the next edge. `RANDOM` retains its last value afterwards.
- **EN while READY:** `EN` falling in the same cycle as the `READY` entry has no effect on the held bit.
- **Outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `trng_pkg`: `trng_state_t` enum, plus localparam helpers for the divider width (`$clog2(SAMPLE_DIV)`) and the repetition counter width (`$clog2(REP_LIMIT+1)`).
- Sub-module `sync_ff`: `SYNC_STAGES`-deep 1-bit synchronizer with synchronous reset to 0. It is reusable for `BTNC`.

## Test plan
Bench parameters: `SAMPLE_DIV`=4, `SYNC_STAGES`=2, `REP_LIMIT`=8. The bench changes `ENTROPY_IN` one cycle after each tick.

1. **Reset:** `RST`=1 for 2 cycles mid-`SECOND` → all outputs 0, and `BIT_READY` never rises with `EN`=0.
2. **Single bit:** `EN` high from cycle 0, entropy 1 then 0 → `BIT_READY` rises at cycle 9 with `RANDOM`=1. Drop `EN` at cycle 10; the bit is held. `ACK` at cycle 20 → `BIT_READY`=0 at cycle 21 and state `IDLE`.
3. **Discarded pairs:** pairs 00, 11, 01 → no `BIT_READY` before cycle 25, then `BIT_READY`=1 with `RANDOM`=0 at cycle 25.
4. **Abort:** `EN` dropped at cycle 6 (state `SECOND`) → `IDLE`, no `BIT_READY`. Re-raise at cycle 10 with pair 10 → `BIT_READY` at cycle 19.
5. **Stuck source:** `ENTROPY_IN` constant 1 with `EN` high → `FAULT`=1 at cycle 33 and `BIT_READY` stays 0. `EN`/`ACK` toggling has no effect; `RST` clears `FAULT`.
6. **Stray ACK:** `ACK` pulses during `FIRST`/`SECOND` are ignored and latency is unchanged. `ACK` in the first `READY` cycle → `BIT_READY` high for exactly 1 cycle.
